// File: rtl/ncore_pkg.sv
// Shared types and helpers for the N x N, K-in-a-row game engine.
package ncore_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        P1_TURN = 2'b00,
        P2_TURN = 2'b01,
        CHECK   = 2'b10,
        DONE    = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        P1W  = 2'b01,
        P2W  = 2'b10,
        DRAW = 2'b11
    } winner_t;

    function automatic int cell_idx(input int n, input int row, input int col);
        return row * n + col;
    endfunction

endpackage

// File: rtl/ncore_win_detect.sv
// Combinational K-in-a-row detector: scans every horizontal, vertical,
// diagonal and anti-diagonal K-window of the board for the given player.
module ncore_win_detect
    import ncore_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 3
) (
    input  logic [2*N*N-1:0] board,
    input  cell_t            player,
    output logic             hasWin
);

    localparam int NDIR = 4;

    logic [NDIR*N*N-1:0] hits;

    // Walks K cells from start with a fixed index stride.
    function automatic logic lineMatch(input logic [2*N*N-1:0] b, input cell_t p,
                                       input int start, input int step);
        logic m;
        m = 1'b1;
        for (int k = 0; k < K; k++) begin
            m &= (b[2*(start + k*step) +: 2] == p);
        end
        return m;
    endfunction

    for (genvar r = 0; r < N; r++) begin : gRow
        for (genvar c = 0; c < N; c++) begin : gCol
            localparam int S = cell_idx(N, r, c);
            localparam int B = NDIR * S;

            if (c + K <= N) begin : gHor
                assign hits[B] = lineMatch(board, player, S, 1);
            end else begin : gHorNone
                assign hits[B] = 1'b0;
            end

            if (r + K <= N) begin : gVer
                assign hits[B+1] = lineMatch(board, player, S, N);
            end else begin : gVerNone
                assign hits[B+1] = 1'b0;
            end

            if ((r + K <= N) && (c + K <= N)) begin : gDiag
                assign hits[B+2] = lineMatch(board, player, S, N + 1);
            end else begin : gDiagNone
                assign hits[B+2] = 1'b0;
            end

            if ((r + K <= N) && (c >= K - 1)) begin : gAnti
                assign hits[B+3] = lineMatch(board, player, S, N - 1);
            end else begin : gAntiNone
                assign hits[B+3] = 1'b0;
            end
        end
    end

    assign hasWin = |hits;

endmodule

// File: rtl/ncore_game.sv
// N x N, K-in-a-row two-player game engine: move legality, turn tracking,
// one-cycle win/draw evaluation and restart without reset.
//   state   | meaning
//   P1_TURN | waiting for a player-1 move
//   P2_TURN | waiting for a player-2 move
//   CHECK   | evaluating the last move on the registered board
//   DONE    | game over, board and winner held until newGame/reset
module ncore_game
    import ncore_pkg::*;
#(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int IW = $clog2(N*N)
) (
    input  logic                      ph2_ncore,
    input  logic                      reset_ncore,
    input  logic                      isPlayer1Start_ncore,
    input  logic                      newGame_ncore,
    input  logic                      playerWrite_ncore,
    input  logic [IW-1:0]             playerInput_ncore,
    output logic [2*N*N-1:0]          gBoard_ncore,
    output logic [1:0]                gameState_ncore,
    output logic [1:0]                winner_ncore,
    output logic                      moveAck_ncore,
    output logic                      moveErr_ncore,
    output logic [$clog2(N*N+1)-1:0]  moveCount_ncore
);

    localparam int CELLS = N * N;
    localparam int CW    = $clog2(N*N + 1);
    localparam logic [CW-1:0] FULL = CW'(CELLS);

    state_t            state, stateNext, startState;
    winner_t           winner;
    cell_t             lastMover, moverCode;
    logic [2*N*N-1:0]  board;
    logic [CW-1:0]     moveCount;
    logic              moveAck, moveErr;
    logic [1:0]        targetCell;
    logic              inTurn, acceptMove, rejectMove, hasWin;

    ncore_win_detect #(.N(N), .K(K)) uWinDetect (
        .board  (board),
        .player (lastMover),
        .hasWin (hasWin)
    );

    always_ff @(posedge ph2_ncore) begin
        if (reset_ncore || newGame_ncore) begin
            state <= startState;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            P1_TURN, P2_TURN: if (acceptMove) stateNext = CHECK;
            CHECK: begin
                if (hasWin || moveCount == FULL) begin
                    stateNext = DONE;
                end else begin
                    stateNext = (lastMover == P1) ? P2_TURN : P1_TURN;
                end
            end
            default: stateNext = DONE;
        endcase
    end

    // Out-of-range indices read as an occupied cell so they are rejected.
    always_comb begin
        targetCell = 2'b11;
        for (int i = 0; i < CELLS; i++) begin
            if (int'(playerInput_ncore) == i) targetCell = board[2*i +: 2];
        end
        startState      = isPlayer1Start_ncore ? P1_TURN : P2_TURN;
        moverCode       = (state == P2_TURN) ? P2 : P1;
        inTurn          = (state == P1_TURN) || (state == P2_TURN);
        acceptMove      = playerWrite_ncore && inTurn && (targetCell == EMPTY);
        rejectMove      = playerWrite_ncore && !acceptMove;
        gameState_ncore = state;
    end

    always_ff @(posedge ph2_ncore) begin
        if (reset_ncore || newGame_ncore) begin
            board     <= '0;
            winner    <= NONE;
            moveCount <= '0;
            moveAck   <= 1'b0;
            moveErr   <= 1'b0;
            lastMover <= P1;
        end else begin
            moveAck <= acceptMove;
            moveErr <= rejectMove;
            if (acceptMove) begin
                for (int i = 0; i < CELLS; i++) begin
                    if (int'(playerInput_ncore) == i) board[2*i +: 2] <= moverCode;
                end
                moveCount <= moveCount + CW'(1);
                lastMover <= moverCode;
            end
            if (state == CHECK) begin
                if (hasWin) begin
                    winner <= (lastMover == P1) ? P1W : P2W;
                end else if (moveCount == FULL) begin
                    winner <= DRAW;
                end
            end
        end
    end

    assign gBoard_ncore    = board;
    assign winner_ncore    = winner;
    assign moveAck_ncore   = moveAck;
    assign moveErr_ncore   = moveErr;
    assign moveCount_ncore = moveCount;

endmodule

// File: tb/tb_ncore_game.sv
// Bench for ncore_game: a 3x3/K=3 and a 4x4/K=3 instance, each checked every
// cycle against a coordinate-based game model, plus directed literal checks.
module tb_ncore_game;

    localparam int KW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstL[2], ngL[2], p1sL[2], wrL[2];
    logic [3:0] idxL[2];

    logic [17:0] gb3;
    logic [1:0]  gs3, wn3;
    logic        ack3, err3;
    logic [3:0]  cnt3;
    logic [31:0] gb4;
    logic [1:0]  gs4, wn4;
    logic        ack4, err4;
    logic [4:0]  cnt4;

    ncore_game #(.N(3), .K(3)) u3 (
        .ph2_ncore(clk), .reset_ncore(rstL[0]), .isPlayer1Start_ncore(p1sL[0]),
        .newGame_ncore(ngL[0]), .playerWrite_ncore(wrL[0]), .playerInput_ncore(idxL[0]),
        .gBoard_ncore(gb3), .gameState_ncore(gs3), .winner_ncore(wn3),
        .moveAck_ncore(ack3), .moveErr_ncore(err3), .moveCount_ncore(cnt3)
    );

    ncore_game #(.N(4), .K(3)) u4 (
        .ph2_ncore(clk), .reset_ncore(rstL[1]), .isPlayer1Start_ncore(p1sL[1]),
        .newGame_ncore(ngL[1]), .playerWrite_ncore(wrL[1]), .playerInput_ncore(idxL[1]),
        .gBoard_ncore(gb4), .gameState_ncore(gs4), .winner_ncore(wn4),
        .moveAck_ncore(ack4), .moveErr_ncore(err4), .moveCount_ncore(cnt4)
    );

    // Model: phase 0 = waiting for a move, 1 = evaluating, 2 = game over.
    int mb[2][64];
    int mTurn[2], mPhase[2], mMover[2], mWin[2], mCnt[2];
    bit mAck[2], mErr[2], mValid[2];

    int checks = 0;
    int failures = 0;
    logic [1:0] lastState;
    logic       lastAck, lastErr;

    function automatic int nOf(input int l);
        return (l == 0) ? 3 : 4;
    endfunction

    function automatic bit wins(input int l, input int p);
        int n;
        int dr[4];
        int dc[4];
        n = nOf(l);
        dr = '{0, 1, 1, 1};
        dc = '{1, 0, 1, -1};
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                for (int d = 0; d < 4; d++) begin
                    bit ok;
                    ok = 1'b1;
                    for (int k = 0; k < KW; k++) begin
                        int rr, cc;
                        rr = r + k*dr[d];
                        cc = c + k*dc[d];
                        if (rr < 0 || rr >= n || cc < 0 || cc >= n) ok = 1'b0;
                        else if (mb[l][rr*n + cc] != p) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    task automatic modelStep(input int l);
        int n;
        int ix;
        n = nOf(l);
        ix = int'(idxL[l]);
        if (rstL[l] === 1'b1 || ngL[l] === 1'b1) begin
            for (int i = 0; i < 64; i++) mb[l][i] = 0;
            mCnt[l] = 0; mWin[l] = 0; mAck[l] = 0; mErr[l] = 0; mPhase[l] = 0;
            mTurn[l] = p1sL[l] ? 1 : 2;
            mMover[l] = mTurn[l];
            mValid[l] = 1'b1;
        end else if (mValid[l]) begin
            mAck[l] = 0;
            mErr[l] = 0;
            case (mPhase[l])
                0: if (wrL[l]) begin
                    if (ix < n*n && mb[l][ix] == 0) begin
                        mb[l][ix] = mTurn[l];
                        mCnt[l]++;
                        mAck[l] = 1;
                        mMover[l] = mTurn[l];
                        mPhase[l] = 1;
                    end else begin
                        mErr[l] = 1;
                    end
                end
                1: begin
                    if (wins(l, mMover[l])) begin
                        mWin[l] = mMover[l]; mPhase[l] = 2;
                    end else if (mCnt[l] == n*n) begin
                        mWin[l] = 3; mPhase[l] = 2;
                    end else begin
                        mTurn[l] = 3 - mMover[l]; mPhase[l] = 0;
                    end
                    if (wrL[l]) mErr[l] = 1;
                end
                default: if (wrL[l]) mErr[l] = 1;
            endcase
        end
    endtask

    task automatic chk(input int l, input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL lane%0d %s t=%0t got=%0h exp=%0h", l, name, $time, got, exp);
        end
    endtask

    task automatic getDut(input int l, output logic [127:0] gb, output logic [1:0] gs,
                          output logic [1:0] wn, output logic a, output logic e, output int cnt);
        if (l == 0) begin
            gb = 128'(gb3); gs = gs3; wn = wn3; a = ack3; e = err3; cnt = int'(cnt3);
        end else begin
            gb = 128'(gb4); gs = gs4; wn = wn4; a = ack4; e = err4; cnt = int'(cnt4);
        end
    endtask

    task automatic checkLane(input int l);
        logic [127:0] gb, eb;
        logic [1:0] gs, wn;
        logic a, e;
        int cnt, es, n;
        n = nOf(l);
        getDut(l, gb, gs, wn, a, e, cnt);
        eb = '0;
        for (int i = 0; i < n*n; i++) eb[2*i +: 2] = 2'(mb[l][i]);
        es = (mPhase[l] == 0) ? mTurn[l] - 1 : (mPhase[l] == 1) ? 2 : 3;
        chk(l, "board", gb, eb);
        chk(l, "state", 128'(gs), 128'(es));
        chk(l, "winner", 128'(wn), 128'(mWin[l]));
        chk(l, "ack", 128'(a), 128'(mAck[l]));
        chk(l, "err", 128'(e), 128'(mErr[l]));
        chk(l, "count", 128'(cnt), 128'(mCnt[l]));
    endtask

    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) modelStep(l);
        #1;
        for (int l = 0; l < 2; l++) if (mValid[l]) checkLane(l);
    end

    task automatic pin(input int l, input string name, input logic [127:0] exp);
        logic [127:0] gb;
        logic [1:0] gs, wn;
        logic a, e;
        int cnt;
        getDut(l, gb, gs, wn, a, e, cnt);
        case (name)
            "board":  chk(l, "pin_board", gb, exp);
            "state":  chk(l, "pin_state", 128'(gs), exp);
            "winner": chk(l, "pin_winner", 128'(wn), exp);
            "ack":    chk(l, "pin_ack", 128'(a), exp);
            "err":    chk(l, "pin_err", 128'(e), exp);
            default:  chk(l, "pin_count", 128'(cnt), exp);
        endcase
    endtask

    task automatic sampleMid(input int l);
        logic [127:0] gb;
        logic [1:0] wn;
        int cnt;
        getDut(l, gb, lastState, wn, lastAck, lastErr, cnt);
    endtask

    task automatic playMove(input int l, input int i);
        @(negedge clk);
        wrL[l] = 1'b1;
        idxL[l] = 4'(i);
        @(negedge clk);
        wrL[l] = 1'b0;
        sampleMid(l);
        @(negedge clk);
    endtask

    task automatic newGame(input int l, input logic p1);
        @(negedge clk);
        ngL[l] = 1'b1;
        p1sL[l] = p1;
        @(negedge clk);
        ngL[l] = 1'b0;
    endtask

    initial begin
        int seq3[9];
        for (int l = 0; l < 2; l++) begin
            rstL[l] = 1'b1; ngL[l] = 1'b0; p1sL[l] = 1'b1; wrL[l] = 1'b0; idxL[l] = '0;
        end
        repeat (2) @(negedge clk);
        rstL[0] = 1'b0;
        rstL[1] = 1'b0;
        pin(0, "state", 128'd0);
        pin(0, "count", 128'd0);

        // P1 completes the top row.
        playMove(0, 0); playMove(0, 3); playMove(0, 1); playMove(0, 4);
        playMove(0, 2);
        pin(0, "winner", 128'd1);
        pin(0, "state", 128'd3);
        pin(0, "count", 128'd5);
        chk(0, "pin_mid_state", 128'(lastState), 128'd2);
        chk(0, "pin_mid_ack", 128'(lastAck), 128'd1);

        // P2 starts, then P1 tries the occupied centre and two bad indices.
        newGame(0, 1'b0);
        pin(0, "state", 128'd1);
        playMove(0, 4);
        pin(0, "board", 128'h200);
        playMove(0, 4);
        chk(0, "pin_dup_err", 128'(lastErr), 128'd1);
        pin(0, "board", 128'h200);
        playMove(0, 9);
        chk(0, "pin_idx9_err", 128'(lastErr), 128'd1);
        playMove(0, 15);
        chk(0, "pin_idx15_err", 128'(lastErr), 128'd1);
        pin(0, "count", 128'd1);

        // Full board with no line is a draw.
        newGame(0, 1'b1);
        seq3 = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        foreach (seq3[j]) playMove(0, seq3[j]);
        pin(0, "winner", 128'd3);
        pin(0, "count", 128'd9);
        pin(0, "board", 128'({2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01}));

        // Writes in DONE fail; newGame beats a simultaneous write.
        playMove(0, 7);
        chk(0, "pin_done_err", 128'(lastErr), 128'd1);
        @(negedge clk);
        ngL[0] = 1'b1; wrL[0] = 1'b1; idxL[0] = 4'd0; p1sL[0] = 1'b0;
        @(negedge clk);
        ngL[0] = 1'b0; wrL[0] = 1'b0;
        pin(0, "board", 128'd0);
        pin(0, "ack", 128'd0);
        pin(0, "err", 128'd0);
        pin(0, "state", 128'd1);

        // Reset while evaluating a move.
        newGame(0, 1'b1);
        @(negedge clk);
        wrL[0] = 1'b1; idxL[0] = 4'd0;
        @(negedge clk);
        wrL[0] = 1'b0;
        pin(0, "state", 128'd2);
        rstL[0] = 1'b1;
        @(negedge clk);
        rstL[0] = 1'b0;
        pin(0, "board", 128'd0);
        pin(0, "winner", 128'd0);
        pin(0, "count", 128'd0);
        pin(0, "state", 128'd0);

        // 4x4, K=3: anti-diagonal, then three in row 3 starting at column 1.
        newGame(1, 1'b1);
        playMove(1, 2); playMove(1, 0); playMove(1, 5); playMove(1, 1);
        playMove(1, 8);
        pin(1, "winner", 128'd1);
        pin(1, "state", 128'd3);
        newGame(1, 1'b1);
        playMove(1, 13); playMove(1, 0); playMove(1, 14); playMove(1, 4);
        playMove(1, 15);
        pin(1, "winner", 128'd1);
        pin(1, "count", 128'd5);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                int n;
                n = nOf(l);
                rstL[l] = ($urandom_range(0, 199) == 0);
                ngL[l]  = ($urandom_range(0, 39) == 0);
                p1sL[l] = 1'($urandom_range(0, 1));
                wrL[l]  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) idxL[l] = 4'($urandom_range(0, 15));
                else idxL[l] = 4'($urandom_range(0, n*n - 1));
            end
        end
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            rstL[l] = 1'b0; ngL[l] = 1'b0; wrL[l] = 1'b0;
        end
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
